// File: rtl/dma_pkg.sv
// Shared definitions for the block-memory DMA initiator: default widths, FSM state
// encoding and the word-slice helper for flattened block arrays.
package dma_pkg;

    localparam int ADDR_WIDTH_DEF = 16;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int BLOCK_SIZE_DEF = 25;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        READ_REQ  = 3'd2,
        READ_WAIT = 3'd3,
        HOLD      = 3'd4
    } dma_init_state_t;

    // LSB position of word k inside a flattened block (word k at [k*dw +: dw]).
    function automatic int word_lsb(input int k, input int dw);
        return k * dw;
    endfunction

endpackage

// File: rtl/dma_block_initiator.sv
// DMA block initiator: streams source words into DMA memory, issues one block read,
// captures the block and hands it on over valid/ready. DMA_BLOCK_PERF_EN adds busy_cycles.
//
// state     | meaning
// IDLE      | waiting for start; done pulses here after a completed operation
// WRITE     | one memory write per accepted source word
// READ_REQ  | single-cycle block-read request
// READ_WAIT | DMA output valid; captured into blk_data at the closing edge
// HOLD      | blk_valid high until the consumer accepts
module dma_block_initiator
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BLOCK_SIZE = BLOCK_SIZE_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    input  logic [ADDR_WIDTH-1:0]            word_count,
    output logic                             busy,
    output logic                             done,
    input  logic [DATA_WIDTH-1:0]            src_data,
    input  logic                             src_valid,
    output logic                             src_ready,
    output logic                             mem_enable,
    output logic                             mem_rw,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_rdata,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] blk_data,
    output logic                             blk_valid,
    input  logic                             blk_ready
`ifdef DMA_BLOCK_PERF_EN
    ,
    output logic [31:0]                      busy_cycles
`endif
);

    localparam logic [2:0] ST_IDLE      = IDLE;
    localparam logic [2:0] ST_WRITE     = WRITE;
    localparam logic [2:0] ST_READ_REQ  = READ_REQ;
    localparam logic [2:0] ST_READ_WAIT = READ_WAIT;
    localparam logic [2:0] ST_HOLD      = HOLD;

    logic [2:0]                      state_q, state_d;
    logic [ADDR_WIDTH-1:0]           base_q, base_d;
    logic [ADDR_WIDTH-1:0]           count_q, count_d;
    logic [ADDR_WIDTH-1:0]           wr_cnt_q, wr_cnt_d;
    logic [BLOCK_SIZE*DATA_WIDTH-1:0] blk_data_q, blk_data_d;
    logic                            done_q, done_d;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        wr_cnt_d   = wr_cnt_q;
        blk_data_d = blk_data_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    count_d  = word_count;
                    wr_cnt_d = '0;
                    state_d  = (word_count != '0) ? ST_WRITE : ST_READ_REQ;
                end
            end
            ST_WRITE: begin
                if (src_valid) begin
                    wr_cnt_d = wr_cnt_q + ADDR_WIDTH'(1);
                    if (wr_cnt_q == count_q - ADDR_WIDTH'(1)) begin
                        state_d = ST_READ_REQ;
                    end
                end
            end
            ST_READ_REQ: begin
                state_d = ST_READ_WAIT;
            end
            ST_READ_WAIT: begin
                for (int k = 0; k < BLOCK_SIZE; k++) begin
                    blk_data_d[word_lsb(k, DATA_WIDTH) +: DATA_WIDTH] =
                        mem_rdata[word_lsb(k, DATA_WIDTH) +: DATA_WIDTH];
                end
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (blk_ready) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            count_q    <= '0;
            wr_cnt_q   <= '0;
            blk_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            wr_cnt_q   <= wr_cnt_d;
            blk_data_q <= blk_data_d;
            done_q     <= done_d;
        end
    end

    // Write address and data are forced to zero whenever no write is issued.
    always_comb begin
        busy        = (state_q != ST_IDLE);
        done        = done_q;
        src_ready   = (state_q == ST_WRITE);
        mem_rw      = (state_q == ST_READ_REQ);
        mem_enable  = ((state_q == ST_WRITE) && src_valid) || (state_q == ST_READ_REQ);
        mem_address = '0;
        mem_wdata   = '0;
        if ((state_q == ST_WRITE) && src_valid) begin
            mem_address = base_q + wr_cnt_q;
            mem_wdata   = src_data;
        end
        blk_valid   = (state_q == ST_HOLD);
        blk_data    = blk_data_q;
    end

`ifdef DMA_BLOCK_PERF_EN
    logic [31:0] busy_cycles_q, busy_cycles_d;

    always_comb begin
        busy_cycles_d = busy_cycles_q;
        if ((state_q == ST_IDLE) && start) begin
            busy_cycles_d = '0;
        end else if ((state_q != ST_IDLE) && (busy_cycles_q != '1)) begin
            busy_cycles_d = busy_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cycles_q <= '0;
        end else begin
            busy_cycles_q <= busy_cycles_d;
        end
    end

    assign busy_cycles = busy_cycles_q;
`endif

endmodule

// File: tb/tb_dma_block_initiator.sv
// Scoreboard bench for dma_block_initiator: randomized and directed operations against
// an address/data/latency reference computed from the operation parameters.
module tb_dma_block_initiator;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int BS = 25;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [AW-1:0]     base_addr = '0;
    logic [AW-1:0]     word_count = '0;
    logic              busy, done;
    logic [DW-1:0]     src_data = '0;
    logic              src_valid = 1'b0;
    logic              src_ready;
    logic              mem_enable, mem_rw;
    logic [AW-1:0]     mem_address;
    logic [DW-1:0]     mem_wdata;
    logic [BS*DW-1:0]  mem_rdata = '0;
    logic [BS*DW-1:0]  blk_data;
    logic              blk_valid;
    logic              blk_ready = 1'b0;
`ifdef DMA_BLOCK_PERF_EN
    logic [31:0]       busy_cycles;
`endif

    dma_block_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_SIZE(BS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done), .src_data(src_data),
        .src_valid(src_valid), .src_ready(src_ready), .mem_enable(mem_enable),
        .mem_rw(mem_rw), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .blk_data(blk_data), .blk_valid(blk_valid),
        .blk_ready(blk_ready)
`ifdef DMA_BLOCK_PERF_EN
        , .busy_cycles(busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails = 0;
    int cyc = 0;

    logic [31:0]      exp_wr_q[$];
    logic [BS*DW-1:0] exp_blk_q[$];
    logic [DW-1:0]    op_words[$];
    logic             valid_pat[64];
    logic [BS*DW-1:0] cur_block;
    int src_idx = 0;
    int pat_i = 0;
    int rdy_wait = 0;
    bit drv_active = 0;

    int wr_seen, rd_seen, done_cnt, rd_cyc, blkv_cyc, hs_cyc, done_cyc;
    bit hold_seen, hold_unstable, busy_gap, in_op;
    logic [BS*DW-1:0] hold_ref;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // DMA slave model: block output registered at the request edge, junk otherwise.
    always @(posedge clk) begin
        logic [BS*DW-1:0] junk;
        for (int k = 0; k < BS; k++) junk[k*DW +: DW] = DW'($urandom);
        if (mem_enable && mem_rw) mem_rdata <= cur_block;
        else mem_rdata <= junk;
    end

    // Source and consumer driver, updated just after each active edge.
    always @(posedge clk) begin
        if (src_valid && src_ready) src_idx++;
        #1;
        if (drv_active && pat_i < 64) begin
            src_valid = valid_pat[pat_i];
            pat_i++;
        end else begin
            src_valid = 1'b0;
        end
        src_data = (src_idx < op_words.size()) ? op_words[src_idx] : DW'($urandom);
        if (blk_valid) begin
            if (rdy_wait > 0) begin
                blk_ready = 1'b0;
                rdy_wait--;
            end else begin
                blk_ready = 1'b1;
            end
        end else begin
            blk_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_enable && !mem_rw) begin
                if (exp_wr_q.size() == 0) begin
                    chk("unexpected_write", {mem_address, mem_wdata}, 32'h0);
                end else begin
                    logic [31:0] e;
                    e = exp_wr_q.pop_front();
                    chk("write_addr", mem_address, e[31:16]);
                    chk("write_data", mem_wdata, e[15:0]);
                end
                wr_seen++;
            end
            if (mem_enable && mem_rw) begin
                rd_seen++;
                rd_cyc = cyc;
            end
            if (blk_valid) begin
                if (!hold_seen) begin
                    blkv_cyc = cyc;
                    hold_ref = blk_data;
                    hold_seen = 1;
                end else if (blk_data !== hold_ref) begin
                    hold_unstable = 1;
                end
                if (blk_ready) begin
                    hs_cyc = cyc;
                    if (exp_blk_q.size() == 0) begin
                        chk("unexpected_block", 64'(blk_valid), 64'(exp_blk_q.size()));
                    end else begin
                        logic [BS*DW-1:0] eb;
                        eb = exp_blk_q.pop_front();
                        vectors++;
                        if (blk_data !== eb) begin
                            fails++;
                            $display("FAIL blk_data: got %h expected %h", blk_data, eb);
                        end
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                in_op = 0;
            end else if (in_op && !busy) begin
                busy_gap = 1;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_src_ready"}, src_ready, 0);
        chk({tag, "_mem_enable"}, mem_enable, 0);
        chk({tag, "_mem_rw"}, mem_rw, 0);
        chk({tag, "_mem_address"}, mem_address, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_blk_valid"}, blk_valid, 0);
        chk({tag, "_blk_data_zero"}, 64'(blk_data != '0), 0);
    endtask

    // mode: 0 full rate, 1 random valid, 2 directed toggle 1,0,0,1,1,0,1
    task automatic run_op(input logic [AW-1:0] base, input int n, input int mode,
                          input int rdelay, input bit mid_start, input bit abort);
        int c0, nth, ones, exp_rd;
        @(negedge clk);
        op_words.delete();
        exp_wr_q.delete();
        exp_blk_q.delete();
        for (int k = 0; k < n; k++) begin
            op_words.push_back(DW'($urandom));
            exp_wr_q.push_back({AW'(base + AW'(k)), op_words[k]});
        end
        for (int k = 0; k < BS; k++) cur_block[k*DW +: DW] = DW'($urandom);
        exp_blk_q.push_back(cur_block);
        for (int i = 0; i < 64; i++) begin
            if (mode == 0 || i >= 48) valid_pat[i] = 1'b1;
            else if (mode == 2) valid_pat[i] = (i < 7) ? ((7'b1011001 >> i) & 1) : 1'b1;
            else valid_pat[i] = 1'($urandom_range(0, 1));
        end
        // expected read-request cycle offset: one past the cycle of the n-th valid word
        ones = 0;
        nth = -1;
        for (int i = 0; i < 64 && nth < 0; i++) begin
            if (valid_pat[i]) ones++;
            if (n > 0 && ones == n) nth = i;
        end
        exp_rd = (n > 0) ? nth + 1 : 0;
        wr_seen = 0; rd_seen = 0; done_cnt = 0; hold_seen = 0;
        hold_unstable = 0; busy_gap = 0;
        rd_cyc = -1; blkv_cyc = -1; hs_cyc = -1; done_cyc = -1;
        src_idx = 0; pat_i = 0; rdy_wait = rdelay; drv_active = 1;
        base_addr = base; word_count = AW'(n); start = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        in_op = 1;
        start = 1'b0;
        base_addr = AW'($urandom);
        word_count = AW'($urandom);
        for (int t = 0; t < 300 && done_cnt == 0; t++) begin
            @(posedge clk); #2;
            start = (mid_start && t == 0);
            if (abort && wr_seen >= 2) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("abort");
                @(posedge clk); #2;
                rst_n = 1'b1;
                drv_active = 0;
                in_op = 0;
                exp_wr_q.delete();
                exp_blk_q.delete();
                repeat (4) @(posedge clk);
                chk("abort_no_done", done_cnt, 0);
                chk("abort_no_block", 64'(hold_seen), 0);
                return;
            end
        end
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        drv_active = 0;
        chk("done_count", done_cnt, 1);
        chk("write_count", wr_seen, n);
        chk("read_count", rd_seen, 1);
        chk("rd_cycle", rd_cyc - c0, exp_rd);
        chk("blk_valid_cycle", blkv_cyc - c0, exp_rd + 2);
        chk("handshake_cycle", hs_cyc - c0, exp_rd + 2 + rdelay);
        chk("done_cycle", done_cyc - hs_cyc, 1);
        chk("hold_stable", 64'(hold_unstable), 0);
        chk("busy_held", 64'(busy_gap), 0);
        chk("queues_empty", exp_wr_q.size() + exp_blk_q.size(), 0);
`ifdef DMA_BLOCK_PERF_EN
        chk("busy_cycles", busy_cycles, done_cyc - c0);
`endif
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_op(16'h0010, 3, 0, 0, 0, 0);
        run_op(16'h0123, 0, 0, 0, 0, 0);
        run_op(16'h0200, 4, 2, 0, 0, 0);
        run_op(16'h0300, 2, 0, 5, 0, 0);
        run_op(16'hFFFE, 3, 0, 1, 1, 0);
        run_op(16'h0400, 5, 0, 0, 0, 1);
        run_op(16'h0500, 5, 0, 0, 0, 0);
        for (int r = 0; r < 20; r++) begin
            logic [AW-1:0] b;
            b = ($urandom_range(0, 3) == 0) ? AW'(16'hFFF8 + $urandom_range(0, 7)) : AW'($urandom);
            run_op(b, $urandom_range(0, 8), $urandom_range(0, 1), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
